trig_sequencer: RTL and testbench

TRIG_SEQUENCER -- requirements
Module: trig_sequencer

---
 rtl/trig_sequencer_pkg.sv | 20 ++
 rtl/trig_sign_fix.sv | 35 +++
 rtl/trig_sequencer.sv | 168 ++++++++++++++++
 tb/tb_trig_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_sequencer_pkg.sv
// Shared definitions for the trig sequencer block.
//   DATA_WIDTH  : width of angles in degrees (request, divider and core paths)
//   trig_func_e : function codes carried on req_func / core_func
package trig_sequencer_pkg;

    localparam int DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        FUNC_SIN  = 2'b00,
        FUNC_COS  = 2'b01,
        FUNC_TAN  = 2'b10,
        FUNC_RSVD = 2'b11
    } trig_func_e;

    // True when the code selects a function the core can evaluate.
    function automatic logic func_is_valid(input logic [1:0] func);
        return trig_func_e'(func) != FUNC_RSVD;
    endfunction

endpackage

// File: rtl/trig_sign_fix.sv
// Applies the quadrant sign to an unsigned-magnitude core result.
// The core only evaluates f(r) for a reduced angle 0..90, so the sign of the
// true result depends on the quadrant of the original angle:
//   sin negative in q2/q3, cos negative in q1/q2, tan negative in q1/q3.
// The sign is applied by flipping bit 63 of the IEEE double; all other bits
// pass through untouched (a zero magnitude is flipped as well, giving -0.0).
// Ports:
//   quadrant  in  2   quadrant latched from the divider
//   func      in  2   function code
//   magnitude in  64  core result
//   result    out 64  signed result
module trig_sign_fix
    import trig_sequencer_pkg::*;
(
    input  logic [1:0]  quadrant,
    input  logic [1:0]  func,
    input  logic [63:0] magnitude,
    output logic [63:0] result
);

    logic neg;

    always_comb begin
        neg = 1'b0;
        case (trig_func_e'(func))
            FUNC_SIN: neg = (quadrant == 2'd2) || (quadrant == 2'd3);
            FUNC_COS: neg = (quadrant == 2'd1) || (quadrant == 2'd2);
            FUNC_TAN: neg = (quadrant == 2'd1) || (quadrant == 2'd3);
            default:  neg = 1'b0;
        endcase
    end

    assign result = {magnitude[63] ^ neg, magnitude[62:0]};

endmodule

// File: rtl/trig_sequencer.sv
// Sequences one trig evaluation: latch request, run the range-reduction
// divider, start the core, wait for its result (with timeout), apply the
// quadrant sign and hold the response until it is taken.
// Parameters:
//   DIV_LAT  divider cycles from en_divider to valid quadrant/data_out
//   TIMEOUT  cycles allowed in WAIT for core_done before an error response
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   req_valid/req_ready/req_angle/req_func      request channel
//   resp_valid/resp_ready/resp_result/resp_err  response channel
//   en_divider/div_data_in/div_quadrant/div_data_out  divider interface
//   core_start/core_angle/core_func/core_done/core_result  core interface
//   dbg_state                       current FSM state (observation only)
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// req_ready is high only in IDLE; resp_valid and its payload stay constant
// from entry into RESP until the edge where resp_ready is seen high. Only one
// operation is ever in flight.
module trig_sequencer
    import trig_sequencer_pkg::*;
#(
    parameter int DIV_LAT = 1,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_angle,
    input  logic [1:0]            req_func,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [63:0]           resp_result,
    output logic                  resp_err,
    output logic                  en_divider,
    output logic [DATA_WIDTH-1:0] div_data_in,
    input  logic [1:0]            div_quadrant,
    input  logic [DATA_WIDTH-1:0] div_data_out,
    output logic                  core_start,
    output logic [DATA_WIDTH-1:0] core_angle,
    output logic [1:0]            core_func,
    input  logic                  core_done,
    input  logic [63:0]           core_result,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DIV  = 3'd1,
        CORE = 3'd2,
        WAIT = 3'd3,
        RESP = 3'd4
    } state_e;

    localparam int DIV_CNT_W  = $clog2(DIV_LAT + 2);
    localparam int WAIT_CNT_W = $clog2(TIMEOUT + 1);
    // DIV lasts DIV_LAT+1 cycles: counter runs 0..DIV_LAT.
    localparam logic [DIV_CNT_W-1:0]  DIV_LAST  = DIV_CNT_W'(DIV_LAT);
    // WAIT lasts at most TIMEOUT cycles: counter runs 0..TIMEOUT-1.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

    state_e                  state;
    logic [DIV_CNT_W-1:0]    div_cnt;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic [1:0]              func_q;
    logic [1:0]              quad_q;
    logic [63:0]             signed_result;

    trig_sign_fix u_sign_fix (
        .quadrant  (quad_q),
        .func      (func_q),
        .magnitude (core_result),
        .result    (signed_result)
    );

    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            resp_err    <= 1'b0;
            en_divider  <= 1'b0;
            div_data_in <= '0;
            core_start  <= 1'b0;
            core_angle  <= '0;
            core_func   <= '0;
            div_cnt     <= '0;
            wait_cnt    <= '0;
            func_q      <= '0;
            quad_q      <= '0;
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        func_q    <= req_func;
                        if (!func_is_valid(req_func)) begin
                            // Reserved code: answer with an error, skip the datapath.
                            state       <= RESP;
                            resp_valid  <= 1'b1;
                            resp_err    <= 1'b1;
                            resp_result <= '0;
                        end else begin
                            state       <= DIV;
                            en_divider  <= 1'b1;
                            div_data_in <= req_angle;
                            div_cnt     <= '0;
                        end
                    end
                end
                DIV: begin
                    if (div_cnt == DIV_LAST) begin
                        // Divider output is valid now; core_angle holds the
                        // latched reduced angle from here on.
                        quad_q      <= div_quadrant;
                        core_angle  <= div_data_out;
                        core_func   <= func_q;
                        core_start  <= 1'b1;
                        en_divider  <= 1'b0;
                        div_data_in <= '0;
                        state       <= CORE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                CORE: begin
                    wait_cnt   <= '0;
                    core_angle <= '0;
                    core_func  <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        state       <= RESP;
                        resp_valid  <= 1'b1;
                        resp_err    <= 1'b0;
                        resp_result <= signed_result;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state       <= RESP;
                        resp_valid  <= 1'b1;
                        resp_err    <= 1'b1;
                        resp_result <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state       <= IDLE;
                        resp_valid  <= 1'b0;
                        resp_err    <= 1'b0;
                        resp_result <= '0;
                        req_ready   <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trig_sequencer.sv
// Bench for trig_sequencer. The reference model tracks one operation as
// "samples since the accept edge" (n) and derives every expected output from
// the operation timeline: DIV for n=0..DIV_LAT, start pulse at DIV_LAT+1,
// response from DIV_LAT+3+delay (or DIV_LAT+2+TIMEOUT on timeout).
module tb_trig_sequencer;
    import trig_sequencer_pkg::*;

    localparam int DIV_LAT = 1;
    localparam int TIMEOUT = 64;
    localparam int DW      = DATA_WIDTH;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [DW-1:0] req_angle = '0;
    logic [1:0]    req_func = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [63:0]   resp_result;
    logic          resp_err;
    logic          en_divider;
    logic [DW-1:0] div_data_in;
    logic [1:0]    div_quadrant = '0;
    logic [DW-1:0] div_data_out = '0;
    logic          core_start;
    logic [DW-1:0] core_angle;
    logic [1:0]    core_func;
    logic          core_done = 1'b0;
    logic [63:0]   core_result = '0;
    logic [2:0]    dbg_state;

    always #5 clk = ~clk;

    trig_sequencer #(.DIV_LAT(DIV_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_angle    (req_angle),
        .req_func     (req_func),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_result  (resp_result),
        .resp_err     (resp_err),
        .en_divider   (en_divider),
        .div_data_in  (div_data_in),
        .div_quadrant (div_quadrant),
        .div_data_out (div_data_out),
        .core_start   (core_start),
        .core_angle   (core_angle),
        .core_func    (core_func),
        .core_done    (core_done),
        .core_result  (core_result),
        .dbg_state    (dbg_state)
    );

    // ---------------- counters / model state ----------------
    int errors = 0;
    int checks = 0;

    bit          busy = 1'b0;
    int          n = 0;
    bit          m_rsvd = 1'b0;
    int          m_delay = 0;
    logic [DW-1:0] m_angle = '0;
    logic [1:0]  m_func = '0;
    logic [1:0]  m_quad = '0;
    logic [DW-1:0] m_red = '0;
    logic [63:0] m_core_res = '0;

    int          nxt_delay = 0;
    logic [63:0] nxt_core_res = '0;

    // scoreboard: {err, result}
    logic [64:0] exp_q[$];

    // per-operation observations of the DUT
    int          first_valid_n = -1;
    logic [63:0] first_result = '0;
    logic        first_err = 1'b0;
    bit          en_seen = 1'b0;
    int          valid_cycles = 0;

    // ---------------- model helpers ----------------
    function automatic int resp_start(bit rsvd, int delay);
        if (rsvd) return 0;
        if (delay < TIMEOUT) return DIV_LAT + 3 + delay;
        return DIV_LAT + 2 + TIMEOUT;
    endfunction

    // Sign of the true result from the quadrant: sin < 0 in the lower half
    // plane, cos < 0 in the left half plane, tan = sin/cos.
    function automatic bit result_negative(logic [1:0] f, logic [1:0] q);
        bit s_neg;
        bit c_neg;
        int qi;
        qi    = int'(q);
        s_neg = (qi >= 2);
        c_neg = (((qi + 1) % 4) >= 2);
        if (f == 2'b00) return s_neg;
        if (f == 2'b01) return c_neg;
        if (f == 2'b10) return s_neg ^ c_neg;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t n=%0d)", name, act, exp, $time, n);
        end
    endtask

    // Drive divider/core inputs for the cycle now starting.
    task automatic drive_models();
        if (busy && !m_rsvd && n == DIV_LAT) begin
            div_quadrant = m_quad;
            div_data_out = m_red;
        end else begin
            div_quadrant = 2'($urandom_range(0, 3));
            div_data_out = DW'($urandom);
        end
        if (busy && !m_rsvd && n >= DIV_LAT + 2 && n < DIV_LAT + 2 + TIMEOUT) begin
            core_done   = (n == DIV_LAT + 2 + m_delay);
            core_result = core_done ? m_core_res : {$urandom, $urandom};
        end else begin
            // Stray completions while nothing is waiting must be ignored.
            core_done   = 1'($urandom_range(0, 1));
            core_result = {$urandom, $urandom};
        end
    endtask

    // Advance the model for the edge that just happened.
    task automatic update_model();
        int a;
        int q;
        int r;
        if (busy) begin
            if (n >= resp_start(m_rsvd, m_delay) && resp_ready) begin
                busy = 1'b0;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end else begin
                n++;
            end
        end else if (req_valid && reset_n) begin
            busy       = 1'b1;
            n          = 0;
            m_angle    = req_angle;
            m_func     = req_func;
            m_rsvd     = (req_func == 2'b11);
            m_delay    = nxt_delay;
            m_core_res = nxt_core_res;
            a = int'(req_angle) % 360;
            q = a / 90;
            r = a % 90;
            if (q % 2 == 1) r = 90 - r;
            m_quad = 2'(q);
            m_red  = DW'(r);
            if (m_rsvd || m_delay >= TIMEOUT)
                exp_q.push_back({1'b1, 64'h0});
            else
                exp_q.push_back({1'b0, m_core_res ^ {result_negative(m_func, m_quad), 63'h0}});
        end
    endtask

    // Compare every output that carries meaning this cycle.
    task automatic check_outputs();
        bit e_valid;
        bit e_div;
        bit e_start;
        e_valid = busy && (n >= resp_start(m_rsvd, m_delay));
        e_div   = busy && !m_rsvd && (n <= DIV_LAT);
        e_start = busy && !m_rsvd && (n == DIV_LAT + 1);
        chk("req_ready", 64'(req_ready), 64'(!busy));
        chk("resp_valid", 64'(resp_valid), 64'(e_valid));
        chk("en_divider", 64'(en_divider), 64'(e_div));
        chk("core_start", 64'(core_start), 64'(e_start));
        if (e_div) chk("div_data_in", 64'(div_data_in), 64'(m_angle));
        if (e_start) begin
            chk("core_angle", 64'(core_angle), 64'(m_red));
            chk("core_func", 64'(core_func), 64'(m_func));
        end
        if (e_valid && exp_q.size() != 0) begin
            chk("resp_result", resp_result, exp_q[0][63:0]);
            chk("resp_err", 64'(resp_err), 64'(exp_q[0][64]));
        end
        if (en_divider) en_seen = 1'b1;
        if (busy && resp_valid) begin
            valid_cycles++;
            if (first_valid_n < 0) begin
                first_valid_n = n;
                first_result  = resp_result;
                first_err     = resp_err;
            end
        end
    endtask

    task automatic tick();
        drive_models();
        @(posedge clk);
        update_model();
        #1;
        check_outputs();
    endtask

    // ---------------- driver ----------------
    task automatic do_txn(input logic [DW-1:0] angle, input logic [1:0] func,
                          input int delay, input logic [63:0] cres, input int ready_wait);
        int waited;
        int cyc;
        nxt_delay     = delay;
        nxt_core_res  = cres;
        first_valid_n = -1;
        en_seen       = 1'b0;
        valid_cycles  = 0;
        req_angle     = angle;
        req_func      = func;
        req_valid     = 1'b1;
        resp_ready    = 1'b0;
        tick();
        waited = 0;
        cyc    = 0;
        while (busy && cyc < 300) begin
            // Requests presented while busy must be ignored.
            req_valid = 1'($urandom_range(0, 1));
            req_angle = DW'($urandom_range(0, 719));
            req_func  = 2'($urandom_range(0, 3));
            if (n >= resp_start(m_rsvd, m_delay)) begin
                if (waited >= ready_wait) resp_ready = 1'b1;
                else begin
                    resp_ready = 1'b0;
                    waited++;
                end
            end else begin
                resp_ready = 1'($urandom_range(0, 1));
            end
            tick();
            cyc++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout: operation still open after %0d cycles", cyc);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b0;
    endtask

    task automatic idle(input int cycles);
        req_valid = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            resp_ready = 1'($urandom_range(0, 1));
            tick();
        end
        resp_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, "_resp_err"}, 64'(resp_err), 64'd0);
        chk({tag, "_resp_result"}, resp_result, 64'd0);
        chk({tag, "_en_divider"}, 64'(en_divider), 64'd0);
        chk({tag, "_div_data_in"}, 64'(div_data_in), 64'd0);
        chk({tag, "_core_start"}, 64'(core_start), 64'd0);
        chk({tag, "_core_angle"}, 64'(core_angle), 64'd0);
        chk({tag, "_core_func"}, 64'(core_func), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #12;
        chk_reset_outputs("por");
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle(2);

        // angle 30 sin: q0/r30; resp_valid captured on the 5th edge after accept
        do_txn(16'd30, 2'b00, 0, 64'h3FE0000000000000, 0);
        chk("sin30_latency", 64'(first_valid_n + 1), 64'd5);
        chk("sin30_result", first_result, 64'h3FE0000000000000);
        chk("sin30_err", 64'(first_err), 64'd0);

        do_txn(16'd210, 2'b00, 0, 64'h3FE0000000000000, 0);
        chk("sin210_result", first_result, 64'hBFE0000000000000);

        do_txn(16'd120, 2'b01, 0, 64'h3FE0000000000000, 0);
        chk("cos120_result", first_result, 64'hBFE0000000000000);

        do_txn(16'd315, 2'b10, 2, 64'h3FF0000000000000, 0);
        chk("tan315_result", first_result, 64'hBFF0000000000000);

        do_txn(16'd45, 2'b10, 0, 64'h3FF0000000000000, 0);
        chk("tan45_result", first_result, 64'h3FF0000000000000);

        // reserved func: immediate error, divider untouched
        do_txn(16'd77, 2'b11, 0, 64'h0, 0);
        chk("rsvd_latency", 64'(first_valid_n + 1), 64'd1);
        chk("rsvd_err", 64'(first_err), 64'd1);
        chk("rsvd_result", first_result, 64'd0);
        chk("rsvd_en_seen", 64'(en_seen), 64'd0);

        // core never answers: error after exactly TIMEOUT WAIT cycles
        do_txn(16'd100, 2'b00, TIMEOUT + 20, 64'h3FF0000000000000, 0);
        chk("timeout_wait_cycles", 64'(first_valid_n - (DIV_LAT + 2)), 64'd64);
        chk("timeout_err", 64'(first_err), 64'd1);
        chk("timeout_result", first_result, 64'd0);

        // consumer stalls 10 cycles; response must be held for 11 cycles
        do_txn(16'd200, 2'b01, 1, 64'h3FD5555555555555, 10);
        chk("stall_valid_cycles", 64'(valid_cycles), 64'd11);
        chk("stall_result", first_result, 64'hBFD5555555555555);

        // reset in the middle of WAIT abandons the operation
        nxt_delay    = 40;
        nxt_core_res = 64'h3FE0000000000000;
        req_angle    = 16'd150;
        req_func     = 2'b01;
        req_valid    = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < DIV_LAT + 6; i++) tick();
        #2 reset_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        busy = 1'b0;
        exp_q.delete();
        tick();
        tick();
        reset_n = 1'b1;
        idle(TIMEOUT + 10);

        do_txn(16'd30, 2'b00, 0, 64'h3FE0000000000000, 0);
        chk("post_rst_latency", 64'(first_valid_n + 1), 64'd5);
        chk("post_rst_result", first_result, 64'h3FE0000000000000);

        // randomized traffic against the model
        for (int t = 0; t < 40; t++) begin
            int d;
            if ($urandom_range(0, 7) == 0) d = TIMEOUT + int'($urandom_range(0, 5));
            else d = int'($urandom_range(0, 6));
            idle(int'($urandom_range(0, 2)));
            do_txn(DW'($urandom_range(0, 719)), 2'($urandom_range(0, 3)), d,
                   {$urandom, $urandom}, int'($urandom_range(0, 3)));
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
